class_stats_accumulator: RTL and testbench

- Parametrised successor to the Otsu cumulative-probability stage. Consumes one histogram frame (bin index, bin count) and splits it at a latched threshold.
- Produces exact integer class statistics per frame: pixel count and first moment (sum of i*n_i) for background (i < threshold) and foreground (i >= threshold), plus the frame total.
- Downstream divider/variance stages turn these into class probabilities and means. The block itself contains no floating point.

---
 rtl/class_stats_accumulator.sv | 153 +++++++++++++++
 tb/tb_class_stats_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/class_stats_accumulator.sv
// Splits one histogram frame at a latched threshold into bg/fg count and first-moment sums.
// Latency: results valid two edges after the last accepted bin beat (stage-1 product, stage-2 add, total).
// Backpressure: in_ready high only while accumulating; results held with out_valid until out_ready.
module class_stats_accumulator #(
    parameter int BIN_W    = 8,
    parameter int COUNT_W  = 32,
    parameter int MOM_W    = 48,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BIN_W-1:0]   threshold,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIN_W-1:0]   in_bin,
    input  logic [COUNT_W-1:0] in_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] cnt_bg,
    output logic [COUNT_W-1:0] cnt_fg,
    output logic [MOM_W-1:0]   mom_bg,
    output logic [MOM_W-1:0]   mom_fg,
    output logic [COUNT_W-1:0] total,
    output logic               seq_err,
    output logic               ovf
);

    localparam int PROD_W = COUNT_W + BIN_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic               bg;
        logic [COUNT_W-1:0] cnt;
        logic [PROD_W-1:0]  prod;
    } beat_t;

    logic [1:0]       state;
    logic [BIN_W-1:0] thr_q;
    logic [BIN_W-1:0] exp_idx;
    logic             s1_vld;
    beat_t            s1_dat;
    logic             beat_acc;

    logic [COUNT_W:0] cnt_sum;
    logic [MOM_W:0]   mom_sum;
    logic [COUNT_W:0] tot_sum;

    // Carry lands in the extra MSB; the low bits are clamped or left wrapped.
    function automatic logic [COUNT_W:0] cnt_add(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
        logic [COUNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SATURATE && s[COUNT_W]) s[COUNT_W-1:0] = '1;
        return s;
    endfunction

    function automatic logic [MOM_W:0] mom_add(input logic [MOM_W-1:0] a,
                                               input logic [MOM_W-1:0] b);
        logic [MOM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SATURATE && s[MOM_W]) s[MOM_W-1:0] = '1;
        return s;
    endfunction

    assign in_ready = (state == ACCUM);
    assign beat_acc = in_ready && in_valid;

    always_comb begin
        cnt_sum = cnt_add(s1_dat.bg ? cnt_bg : cnt_fg, s1_dat.cnt);
        mom_sum = mom_add(s1_dat.bg ? mom_bg : mom_fg, MOM_W'(s1_dat.prod));
        tot_sum = cnt_add(cnt_bg, cnt_fg);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            thr_q     <= '0;
            exp_idx   <= '0;
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            cnt_bg    <= '0;
            cnt_fg    <= '0;
            mom_bg    <= '0;
            mom_fg    <= '0;
            total     <= '0;
            seq_err   <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // Stage 1: register count, product and class of an accepted beat.
            s1_vld <= beat_acc;
            if (beat_acc) begin
                s1_dat.bg   <= (in_bin < thr_q);
                s1_dat.cnt  <= in_count;
                s1_dat.prod <= PROD_W'(in_bin) * PROD_W'(in_count);
                exp_idx     <= exp_idx + 1'b1;
                if (in_bin != exp_idx) seq_err <= 1'b1;
            end

            // Stage 2: fold the registered beat into its class.
            if (s1_vld) begin
                if (s1_dat.bg) begin
                    cnt_bg <= cnt_sum[COUNT_W-1:0];
                    mom_bg <= mom_sum[MOM_W-1:0];
                end else begin
                    cnt_fg <= cnt_sum[COUNT_W-1:0];
                    mom_fg <= mom_sum[MOM_W-1:0];
                end
                if (cnt_sum[COUNT_W] || mom_sum[MOM_W]) ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        thr_q   <= threshold;
                        exp_idx <= '0;
                        cnt_bg  <= '0;
                        cnt_fg  <= '0;
                        mom_bg  <= '0;
                        mom_fg  <= '0;
                        total   <= '0;
                        seq_err <= 1'b0;
                        ovf     <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_acc && (&exp_idx)) state <= FLUSH;
                end
                FLUSH: begin
                    state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        total     <= tot_sum[COUNT_W-1:0];
                        if (tot_sum[COUNT_W]) ovf <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_class_stats_accumulator.sv
// Directed-vector bench: a wide instance checked per table row, two narrow instances for clamp/wrap.
module tb_class_stats_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  threshold = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_bin = '0;
    logic [31:0] in_count = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, seq_err, ovf;
    logic [31:0] cnt_bg, cnt_fg, total;
    logic [47:0] mom_bg, mom_fg;

    logic        s_in_ready, s_out_valid, s_seq_err, s_ovf;
    logic [7:0]  s_cnt_bg, s_cnt_fg, s_total;
    logic [15:0] s_mom_bg, s_mom_fg;

    logic        w_in_ready, w_out_valid, w_seq_err, w_ovf;
    logic [7:0]  w_cnt_bg, w_cnt_fg, w_total;
    logic [15:0] w_mom_bg, w_mom_fg;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    class_stats_accumulator #(.BIN_W(8), .COUNT_W(32), .MOM_W(48), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_bg(cnt_bg), .cnt_fg(cnt_fg), .mom_bg(mom_bg), .mom_fg(mom_fg),
        .total(total), .seq_err(seq_err), .ovf(ovf));

    class_stats_accumulator #(.BIN_W(8), .COUNT_W(8), .MOM_W(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_bin(in_bin), .in_count(in_count[7:0]),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .cnt_bg(s_cnt_bg), .cnt_fg(s_cnt_fg), .mom_bg(s_mom_bg), .mom_fg(s_mom_fg),
        .total(s_total), .seq_err(s_seq_err), .ovf(s_ovf));

    class_stats_accumulator #(.BIN_W(8), .COUNT_W(8), .MOM_W(16), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_bin(in_bin), .in_count(in_count[7:0]),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .cnt_bg(w_cnt_bg), .cnt_fg(w_cnt_fg), .mom_bg(w_mom_bg), .mom_fg(w_mom_fg),
        .total(w_total), .seq_err(w_seq_err), .ovf(w_ovf));

    typedef struct {
        int      thr;
        int      mode;
        bit      gaps;
        bit      swap;
        bit      hold;
        longint  e_cbg;
        longint  e_cfg;
        longint  e_mbg;
        longint  e_mfg;
        longint  e_tot;
        bit      e_seq;
        bit      e_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_for(input int mode, input int b);
        case (mode)
            0: return 32'd1;
            1: return (b == 0) ? 32'd10 : (b == 255) ? 32'd5 : 32'd0;
            2: return (b < 2) ? 32'd200 : 32'd0;
            default: return 32'(b);
        endcase
    endfunction

    function automatic logic [7:0] bin_for(input bit swap, input int s);
        if (swap && s == 1) return 8'd2;
        if (swap && s == 2) return 8'd1;
        return 8'(s);
    endfunction

    // Called on a negedge; returns on the negedge after the last beat's accepting edge.
    task automatic send_beats(input int nbeats, input int mode, input bit gaps, input bit swap);
        for (int s = 0; s < nbeats; s++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_bin   = bin_for(swap, s);
            in_count = cnt_for(mode, int'(in_bin));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        start     = 1'b1;
        threshold = 8'(v.thr);
        @(negedge clk);
        start     = 1'b0;
        threshold = ~8'(v.thr);
        send_beats(256, v.mode, v.gaps, v.swap);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_latency", 64'(n), 64'd2);
        if (v.hold) begin
            for (int c = 0; c < 20; c++) begin
                start     = (c == 5);
                threshold = 8'd3;
                chk("hold_out_valid", 64'(out_valid), 64'd1);
                chk("hold_in_ready", 64'(in_ready), 64'd0);
                chk("hold_cnt_bg", 64'(cnt_bg), 64'(v.e_cbg));
                chk("hold_mom_fg", 64'(mom_fg), 64'(v.e_mfg));
                @(negedge clk);
            end
            start = 1'b0;
        end
        chk("cnt_bg", 64'(cnt_bg), 64'(v.e_cbg));
        chk("cnt_fg", 64'(cnt_fg), 64'(v.e_cfg));
        chk("mom_bg", 64'(mom_bg), 64'(v.e_mbg));
        chk("mom_fg", 64'(mom_fg), 64'(v.e_mfg));
        chk("total", 64'(total), 64'(v.e_tot));
        chk("seq_err", 64'(seq_err), 64'(v.e_seq));
        chk("ovf", 64'(ovf), 64'(v.e_ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_accept", 64'(out_valid), 64'd0);
        chk("cnt_fg_held", 64'(cnt_fg), 64'(v.e_cfg));
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        //                 thr  mode gaps swap hold  cnt_bg  cnt_fg  mom_bg    mom_fg  total  seq ovf
        vecs[0] = '{128, 0, 1'b0, 1'b0, 1'b0, 128,   128, 8128,    24512, 256,   1'b0, 1'b0};
        vecs[1] = '{0,   1, 1'b0, 1'b0, 1'b0, 0,     15,  0,       1275,  15,    1'b0, 1'b0};
        vecs[2] = '{128, 0, 1'b1, 1'b0, 1'b1, 128,   128, 8128,    24512, 256,   1'b0, 1'b0};
        vecs[3] = '{128, 0, 1'b0, 1'b1, 1'b0, 128,   128, 8128,    24512, 256,   1'b1, 1'b0};
        vecs[4] = '{255, 3, 1'b0, 1'b0, 1'b0, 32385, 255, 5494655, 65025, 32640, 1'b0, 1'b0};
        vecs[5] = '{255, 2, 1'b0, 1'b0, 1'b0, 400,   0,   200,     0,     400,   1'b0, 1'b0};

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cnt_bg", 64'(cnt_bg), 64'd0);
        chk("rst_mom_fg", 64'(mom_fg), 64'd0);
        chk("rst_total", 64'(total), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // start is ignored until the frame completes; a start while idle-ready is the only entry
        for (int r = 0; r < 6; r++) run_frame(vecs[r]);

        // Narrow instances saw the last frame: 200+200 on bg bins of an 8-bit count.
        chk("sat_cnt_bg", 64'(s_cnt_bg), 64'd255);
        chk("sat_ovf", 64'(s_ovf), 64'd1);
        chk("sat_total", 64'(s_total), 64'd255);
        chk("sat_mom_bg", 64'(s_mom_bg), 64'd200);
        chk("wrap_cnt_bg", 64'(w_cnt_bg), 64'd144);
        chk("wrap_ovf", 64'(w_ovf), 64'd1);
        chk("wrap_total", 64'(w_total), 64'd144);

        // Abort a frame after 100 beats, then a fresh frame must be clean.
        start     = 1'b1;
        threshold = 8'd128;
        @(negedge clk);
        start = 1'b0;
        send_beats(100, 0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_cnt_bg", 64'(cnt_bg), 64'd0);
        chk("abort_mom_bg", 64'(mom_bg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk("abort_no_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
